theta_apply_stream: RTL and testbench

- Downstream neighbour of the column-parity stage in the encoder.
- Consumes the 64-slice state as a stream of 25-bit pages and applies the full theta step per slice.
- For each page: out[x,y] = in[x,y] ^ C[x-1][z] ^ C[x+1][z-1], where C is the 5-bit column parity of a slice. The z index wraps mod 64 and x wraps mod 5.
- Slice 0 depends on slice 63, so slice 0 is buffered and emitted last. Output order is z = 1..63, then z = 0.

---
 rtl/theta_apply_stream.sv | 152 +++++++++++++++
 tb/tb_theta_apply_stream.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/theta_apply_stream.sv
// Theta step applied to a stream of 25-bit slice pages.
// Slice 0 is held back and emitted last, once slice 63's parity is known.
module theta_apply_stream #(
  parameter int NUM_SLICES = 64,
  parameter int IDX_W      = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [24:0]      in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [24:0]      out_data,
  output logic [IDX_W-1:0] out_index,
  output logic             busy,
  output logic             done
);

  typedef enum logic [2:0] {
    IDLE, FIRST, STREAM, FLUSH, DONE
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   cnt_q, cnt_d;
  logic [24:0]        page0_q, page0_d;
  logic [4:0]         c0_q, c0_d;
  logic [4:0]         cprev_q, cprev_d;
  logic               ov_q, ov_d;
  logic [24:0]        od_q, od_d;
  logic [IDX_W-1:0]   oi_q, oi_d;

  logic [4:0] ccur;
  logic       out_free;
  logic       accept;

  function automatic logic [4:0] col_par(
    input logic [24:0] p
  );
    logic [4:0] c;
    c = '0;
    for (int y = 0; y < 5; y++) c ^= p[5*y +: 5];
    return c;
  endfunction

  // cz drives x-1 (rotate up), czm1 drives x+1
  function automatic logic [24:0] theta(
    input logic [24:0] p,
    input logic [4:0]  cz,
    input logic [4:0]  czm1
  );
    logic [4:0] d;
    d = {cz[3:0], cz[4]} ^ {czm1[0], czm1[4:1]};
    return p ^ {5{d}};
  endfunction

  assign ccur     = col_par(in_data);
  assign out_free = !ov_q || out_ready;
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    page0_d  = page0_q;
    c0_d     = c0_q;
    cprev_d  = cprev_q;
    ov_d     = ov_q;
    od_d     = od_q;
    oi_d     = oi_q;
    in_ready = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = FIRST;
          cnt_d   = '0;
        end
      end
      FIRST: begin
        in_ready = 1'b1;
        if (in_valid) begin
          page0_d = in_data;
          c0_d    = ccur;
          cprev_d = ccur;
          cnt_d   = IDX_W'(1);
          state_d = STREAM;
        end
      end
      STREAM: begin
        in_ready = out_free;
        if (out_ready) ov_d = 1'b0;
        if (accept) begin
          od_d    = theta(in_data, ccur, cprev_q);
          oi_d    = cnt_q;
          ov_d    = 1'b1;
          cprev_d = ccur;
          if (cnt_q == IDX_W'(NUM_SLICES-1))
            state_d = FLUSH;
          else
            cnt_d = cnt_q + IDX_W'(1);
        end
      end
      FLUSH: begin
        // index 0 only ever appears here, so it marks the loaded z=0 page
        if (ov_q && oi_q == '0) begin
          if (out_ready) begin
            ov_d    = 1'b0;
            state_d = DONE;
          end
        end else if (out_free) begin
          od_d = theta(page0_q, c0_q, cprev_q);
          oi_d = '0;
          ov_d = 1'b1;
        end
      end
      DONE: begin
        ov_d    = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      page0_q <= '0;
      c0_q    <= '0;
      cprev_q <= '0;
      ov_q    <= 1'b0;
      od_q    <= '0;
      oi_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      page0_q <= page0_d;
      c0_q    <= c0_d;
      cprev_q <= cprev_d;
      ov_q    <= ov_d;
      od_q    <= od_d;
      oi_q    <= oi_d;
    end
  end

  assign out_valid = ov_q;
  assign out_data  = od_q;
  assign out_index = oi_q;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);

endmodule

// File: tb/tb_theta_apply_stream.sv
// Bench for theta_apply_stream: directed vectors, random
// backpressure passes, mid-pass reset and start-spam checks.
module tb_theta_apply_stream;

  localparam int NS = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [24:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [24:0] out_data;
  logic [5:0]  out_index;
  logic        busy;
  logic        done;

  theta_apply_stream #(.NUM_SLICES(NS), .IDX_W(6)) dut (
    .clk(clk), .rst(rst), .start(start),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_index(out_index),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  logic [24:0] pages [NS];
  logic [24:0] model [NS];
  logic [24:0] got   [NS];

  typedef struct {
    int          sz;
    logic [24:0] sval;
    int          cz;
    logic [24:0] cexp;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference theta computed directly from lane coordinates
  function automatic void build_model();
    logic [4:0] c [NS];
    for (int z = 0; z < NS; z++)
      for (int x = 0; x < 5; x++) begin
        c[z][x] = 1'b0;
        for (int y = 0; y < 5; y++)
          c[z][x] = c[z][x] ^ pages[z][5*y+x];
      end
    for (int z = 0; z < NS; z++)
      for (int x = 0; x < 5; x++)
        for (int y = 0; y < 5; y++)
          model[z][5*y+x] = pages[z][5*y+x]
                          ^ c[z][(x+4)%5]
                          ^ c[(z+NS-1)%NS][(x+1)%5];
  endfunction

  task automatic run_pass(input int rdy_pct, input int vld_pct,
                          input bit spam, input int abort_at);
    int in_idx = 0;
    int out_cnt = 0;
    int dones = 0;
    int cyc = 0;
    int z;
    bit stalled = 1'b0;
    logic [24:0] pd = '0;
    logic [5:0]  pi = '0;
    build_model();
    for (int i = 0; i < NS; i++) got[i] = '1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    #1 chk("busy_after_start", 32'(busy), 32'(1));
    while (cyc < 3000 && dones == 0) begin
      @(negedge clk);
      cyc++;
      in_valid  = int'($urandom_range(99)) < vld_pct;
      in_data   = (in_idx < NS) ? pages[in_idx] : 25'($urandom);
      out_ready = int'($urandom_range(99)) < rdy_pct;
      start     = spam && ($urandom_range(3) == 0);
      #1;
      if (stalled) begin
        chk("stall_data", 32'(out_data), 32'(pd));
        chk("stall_index", 32'(out_index), 32'(pi));
      end
      if (out_valid && !out_ready)
        chk("in_ready_when_full", 32'(in_ready), 32'(0));
      stalled = out_valid && !out_ready;
      pd = out_data;
      pi = out_index;
      if (out_valid && out_ready) begin
        if (out_cnt < NS) begin
          z = (out_cnt + 1) % NS;
          chk("out_index", 32'(out_index), 32'(z));
          chk("out_data", 32'(out_data), 32'(model[z]));
          got[z] = out_data;
        end
        out_cnt++;
      end
      if (in_valid && in_ready) in_idx++;
      if (done) dones++;
      if (abort_at >= 0 && in_idx == abort_at) begin
        #1 rst = 1'b0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'(0));
        chk("rst_out_data", 32'(out_data), 32'(0));
        chk("rst_out_index", 32'(out_index), 32'(0));
        chk("rst_in_ready", 32'(in_ready), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_done", 32'(done), 32'(0));
        start = 1'b0;
        in_valid = 1'b0;
        @(negedge clk); rst = 1'b1;
        return;
      end
    end
    start = 1'b0;
    in_valid = 1'b0;
    if (dones == 0) chk("pass_timeout", 32'(cyc), 32'(0));
    repeat (3) begin
      @(negedge clk);
      #1 if (done) dones++;
    end
    chk("done_pulses", 32'(dones), 32'(1));
    chk("outputs_seen", 32'(out_cnt), 32'(NS));
    chk("inputs_taken", 32'(in_idx), 32'(NS));
    chk("busy_idle", 32'(busy), 32'(0));
    chk("valid_idle", 32'(out_valid), 32'(0));
  endtask

  initial begin
    vecs[0] = '{0,  25'h0000001, 1,  25'h1084210};
    vecs[1] = '{0,  25'h0000001, 0,  25'h0210843};
    vecs[2] = '{0,  25'h0000001, 2,  25'h0000000};
    vecs[3] = '{63, 25'h0000001, 63, 25'h0210843};
    vecs[4] = '{63, 25'h0000001, 0,  25'h1084210};
    vecs[5] = '{5,  25'h0000001, 5,  25'h0210843};
    vecs[6] = '{5,  25'h0000001, 6,  25'h1084210};
    vecs[7] = '{10, 25'h0020000, 10, 25'h0862108};
    vecs[8] = '{10, 25'h0020000, 11, 25'h0210842};

    #12;
    chk("reset_out_valid", 32'(out_valid), 32'(0));
    chk("reset_out_data", 32'(out_data), 32'(0));
    chk("reset_out_index", 32'(out_index), 32'(0));
    chk("reset_in_ready", 32'(in_ready), 32'(0));
    chk("reset_busy", 32'(busy), 32'(0));
    chk("reset_done", 32'(done), 32'(0));
    @(negedge clk); rst = 1'b1;

    for (int i = 0; i < NS; i++) pages[i] = '0;
    run_pass(100, 100, 1'b0, -1);

    for (int v = 0; v < 9; v++) begin
      for (int i = 0; i < NS; i++) pages[i] = '0;
      pages[vecs[v].sz] = vecs[v].sval;
      run_pass(100, 100, 1'b0, -1);
      chk($sformatf("vec%0d_z%0d", v, vecs[v].cz),
          32'(got[vecs[v].cz]), 32'(vecs[v].cexp));
    end

    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < NS; i++) pages[i] = 25'($urandom);
      run_pass(50, 80, 1'b0, -1);
    end

    for (int i = 0; i < NS; i++) pages[i] = 25'($urandom);
    run_pass(50, 100, 1'b0, 30);
    for (int i = 0; i < NS; i++) pages[i] = '0;
    run_pass(100, 100, 1'b0, -1);

    for (int i = 0; i < NS; i++) pages[i] = 25'($urandom);
    run_pass(60, 90, 1'b1, -1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
